fetch_stage: RTL and testbench

Instruction-fetch control stage sitting between the PC register and the IF/ID boundary of the MIPS pipeline. Reads the current `PC`, drives the instruction-memory request/ready handshake, and computes `nextPC` plus the PC register's `enable`. Also owns the IF/ID pipeline register, including stall buffering and flush on branch/jump redirect.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch control stage: drives the imem request/ready handshake,
// computes the next PC and owns the IF/ID register with stall buffering and redirect flush.
module fetch_stage #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic        pc_enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        handshake;
    logic        flush;
    logic [31:0] pc_seq;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic [31:0] orphan_addr;

    assign pc_seq    = PC + PC_STEP;
    assign nextPC    = redirect ? redirect_pc : pc_seq;
    assign fsm_state = state;

    // Handshake: a transfer happens in exactly the cycles where imem_req and
    // imem_ready are both 1; imem_addr holds steady while a request waits.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        imem_addr  = PC;
        pc_enable  = 1'b0;
        handshake  = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req  = 1'b1;
                handshake = imem_ready;
                if (redirect) begin
                    flush      = 1'b1;
                    pc_enable  = 1'b1;
                    state_next = handshake ? REQ : DISCARD;
                end else if (handshake) begin
                    pc_enable  = 1'b1;
                    state_next = (stall && ifid_valid) ? HOLD : REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush      = 1'b1;
                    pc_enable  = 1'b1;
                    state_next = REQ;
                end else if (!stall) begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                // Drain the response to the request abandoned by a redirect.
                imem_req  = 1'b1;
                imem_addr = orphan_addr;
                handshake = imem_ready;
                if (redirect) begin
                    flush      = 1'b1;
                    pc_enable  = 1'b1;
                    state_next = handshake ? REQ : DISCARD;
                end else if (handshake) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            pc_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ifid_valid  <= 1'b0;
            ifid_instr  <= 32'd0;
            ifid_pc4    <= 32'd0;
            hold_instr  <= 32'd0;
            hold_pc4    <= 32'd0;
            orphan_addr <= 32'd0;
        end else begin
            state <= state_next;
            if (flush) begin
                ifid_valid <= 1'b0;
            end else begin
                case (state)
                    REQ: begin
                        if (handshake) begin
                            if (!stall || !ifid_valid) begin
                                ifid_valid <= 1'b1;
                                ifid_instr <= imem_rdata;
                                ifid_pc4   <= pc_seq;
                            end else begin
                                hold_instr <= imem_rdata;
                                hold_pc4   <= pc_seq;
                            end
                        end else if (!stall) begin
                            ifid_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= hold_instr;
                            ifid_pc4   <= hold_pc4;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == REQ && redirect && !imem_ready) begin
                orphan_addr <= PC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle vector table with a PC register model, an instruction
// memory model and an expected-instruction queue checked when ID consumes IF/ID.
module tb_fetch_stage;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DISC = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        stall;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_pen;
        logic [31:0] exp_npc;
        logic        exp_valid;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(.PC_STEP(32'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (pc),
        .nextPC     (next_pc),
        .pc_enable  (pc_enable),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = word_of(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic rd, input logic [31:0] rpc,
                           input logic st, input logic rdy, input logic e_req,
                           input logic [31:0] e_addr, input logic e_pen,
                           input logic [31:0] e_npc, input logic e_valid,
                           input logic [1:0] e_state);
        vec_t t;
        t.rst = r; t.rd = rd; t.rpc = rpc; t.stall = st; t.rdy = rdy;
        t.exp_req = e_req; t.exp_addr = e_addr; t.exp_pen = e_pen;
        t.exp_npc = e_npc; t.exp_valid = e_valid; t.exp_state = e_state;
        vecs.push_back(t);
    endtask

    initial begin
        logic        pen_s;
        logic [31:0] npc_s;
        logic [63:0] got;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
        imem_ready = 1'b0; pc = 32'd0;

        //       rst rd rpc           st rdy req addr          pen npc           vld state
        add_vec(0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h4,        0, S_IDLE); // c0
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h0,        1, 32'h4,        0, S_REQ);  // c1
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h4,        1, 32'h8,        1, S_REQ);  // c2
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h8,        0, 32'hC,        1, S_REQ);  // c3
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h8,        0, 32'hC,        0, S_REQ);  // c4
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h8,        0, 32'hC,        0, S_REQ);  // c5
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h8,        1, 32'hC,        0, S_REQ);  // c6
        add_vec(0, 0, 32'h0,        1, 1, 1, 32'hC,        1, 32'h10,       1, S_REQ);  // c7
        add_vec(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h14,       1, S_HOLD); // c8
        add_vec(0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h14,       1, S_HOLD); // c9
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h10,       1, 32'h14,       1, S_REQ);  // c10
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h14,       0, 32'h18,       1, S_REQ);  // c11
        add_vec(0, 1, 32'h100,      0, 0, 1, 32'h14,       1, 32'h100,      0, S_REQ);  // c12
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h14,       0, 32'h104,      0, S_DISC); // c13
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h14,       0, 32'h104,      0, S_DISC); // c14
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h100,      1, 32'h104,      0, S_REQ);  // c15
        add_vec(0, 1, 32'h200,      1, 1, 1, 32'h104,      1, 32'h200,      1, S_REQ);  // c16
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h200,      1, 32'h204,      0, S_REQ);  // c17
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h204,      0, 32'h208,      1, S_REQ);  // c18
        add_vec(0, 1, 32'hFFFFFFFC, 0, 1, 1, 32'h204,      1, 32'hFFFFFFFC, 0, S_REQ);  // c19
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'hFFFFFFFC, 1, 32'h0,        0, S_REQ);  // c20
        add_vec(0, 0, 32'h0,        0, 1, 1, 32'h0,        1, 32'h4,        1, S_REQ);  // c21
        add_vec(0, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h8,        1, S_REQ);  // c22
        add_vec(0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'hC,        1, S_HOLD); // c23
        add_vec(1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'hC,        1, S_HOLD); // c24
        add_vec(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h4,        0, S_IDLE); // c25
        add_vec(0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 32'h4,        0, S_REQ);  // c26

        @(negedge clk);
        @(negedge clk);
        check("reset state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        check("reset ifid_valid", {31'd0, ifid_valid}, 32'd0);
        check("reset ifid_instr", ifid_instr, 32'd0);
        check("reset ifid_pc4", ifid_pc4, 32'd0);
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset pc_enable", {31'd0, pc_enable}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t t;
            t = vecs[i];
            rst = t.rst; redirect = t.rd; redirect_pc = t.rpc;
            stall = t.stall; imem_ready = t.rdy;
            #1;
            check($sformatf("c%0d state", i), {30'd0, fsm_state}, {30'd0, t.exp_state});
            check($sformatf("c%0d imem_req", i), {31'd0, imem_req}, {31'd0, t.exp_req});
            if (t.exp_req)
                check($sformatf("c%0d imem_addr", i), imem_addr, t.exp_addr);
            check($sformatf("c%0d pc_enable", i), {31'd0, pc_enable}, {31'd0, t.exp_pen});
            check($sformatf("c%0d nextPC", i), next_pc, t.exp_npc);
            check($sformatf("c%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, t.exp_valid});
            if (i > 0 && vecs[i-1].rst) begin
                check($sformatf("c%0d post-reset instr", i), ifid_instr, 32'd0);
                check($sformatf("c%0d post-reset pc4", i), ifid_pc4, 32'd0);
            end
            // ID consumes IF/ID at the coming edge when it is live and not stalled.
            if (t.exp_valid && !t.stall && !t.rst) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c%0d consume: got %h expected none", i, {ifid_instr, ifid_pc4});
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("c%0d ifid_instr", i), ifid_instr, got[63:32]);
                    check($sformatf("c%0d ifid_pc4", i), ifid_pc4, got[31:0]);
                end
            end
            if (t.rst || (t.rd && t.exp_state != S_IDLE))
                exp_q.delete();
            else if (t.exp_state == S_REQ && t.rdy)
                exp_q.push_back({word_of(t.exp_addr), t.exp_addr + 32'd4});
            pen_s = pc_enable;
            npc_s = next_pc;
            @(posedge clk);
            @(negedge clk);
            if (t.rst) pc = 32'd0;
            else if (pen_s) pc = npc_s;
        end

        check("queue drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
